dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters:
//    m0 = core load/store path, m1 = debug/program loader.
//  Round-robin arbitration, registered req/gnt handshake, fixed-latency read return.
//  Sits between the requesters and data_memory; it is the only driver of the memory port.
// PARAMETERS
//  ADDR_W   32  byte-address width.
//  DATA_W   32  data width.
//  MEM_LAT  1   memory read latency in cycles from mem_en. Legal range 1..4.
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  m0_req     in   1       m0 access request (level)
//  m0_we      in   1       m0 write=1 / read=0
//  m0_addr    in   ADDR_W  m0 byte address
//  m0_wdata   in   DATA_W  m0 write data
//  m0_gnt     out  1       m0 request accepted (1-cycle pulse)
//  m0_rvalid  out  1       m0 read data valid (1-cycle pulse)
//  m0_rdata   out  DATA_W  m0 read data; holds last value
//  m1_*       -    -       same set as m0_*, for requester m1
//  m1_lock    in   1       only with DMEM_ARB_LOCK_EN; m1 burst lock
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  word-aligned address; [1:0] forced to 0
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1       FSM is not in IDLE
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous)
//   - All outputs go to 0, including rdata registers.
//   - FSM -> IDLE; rr_last -> m1, so m0 wins the first tie.
//   - Any read in flight is discarded and no rvalid is issued.
//  FSM states: IDLE, ACCESS, RESP.
//  IDLE
//   - If any req: pick the winner, latch we/addr/wdata/id, go to ACCESS.
//   - Tie (both req): grant the port that is not rr_last.
//  ACCESS (exactly 1 cycle)
//   - mem_en=1, mem_we=latched we, gnt pulse to the winner, rr_last <= winner.
//   - Write: go to IDLE.
//   - Read: load lat_cnt=MEM_LAT-1, go to RESP.
//  RESP
//   - When lat_cnt==0: capture mem_rdata into the winner's rdata, pulse its rvalid, go to IDLE.
//   - Otherwise decrement lat_cnt.
//  Latency
//   - Write: req@N -> gnt@N+1.
//   - Read: gnt@N+1 -> rvalid@N+1+MEM_LAT.
//   - Minimum one IDLE cycle between transactions (max 1 access per 2 cycles).
//  Handshake
//   - Requester holds req/we/addr/wdata stable until gnt, then drops req or presents the next access.
//   - req dropped while in IDLE = withdrawn.
//   - Once latched, the access completes even if req drops.
//   - A loser's req stays pending; fairness: a continuously requesting port waits at most one transaction.
//  Outputs mem_*, gnt, rvalid, rdata, busy are registered; mem_* are 0 outside ACCESS.
//  mem_addr = {addr[ADDR_W-1:2],2'b00}; misaligned low bits are silently dropped.
//  rvalid and gnt are never asserted to both ports in the same cycle.
// CONFIGURATION
//  DMEM_ARB_LOCK_EN defined
//   - m1_lock port exists.
//   - m1_lock=1 sampled in IDLE with m1_req=1 makes m1 win regardless of rr_last.
//   - While m1_lock=1, m0 is never granted; m0 is served on the first IDLE after lock drops.
//  DMEM_ARB_LOCK_EN undefined
//   - m1_lock port is absent; pure round-robin.
// TESTING
//  1. m0 read addr=0x10, MEM_LAT=1, mem_rdata=0xCAFE0001 -> m0_gnt@1, mem_en@1, m0_rvalid@2, m0_rdata=0xCAFE0001.
//  2. m0,m1 both write continuously after reset -> grants m0,m1,m0,m1 every 2 cycles; mem_wdata matches granted port.
//  3. MEM_LAT=3, m1 read addr=0x23 -> mem_addr=0x20, m1_rvalid 3 cycles after m1_gnt, busy high for 4 cycles.
//  4. reset_n low during RESP of m0 read -> all outputs 0 immediately, no m0_rvalid after release, next tie grants m0.
//  5. m0_req high 1 cycle while m1 holds the port -> withdrawn, m0_gnt never pulses.
//  6. LOCK_EN: m1_lock=1, m1 4 reads, m0_req high -> m0_gnt only after lock drops; without LOCK_EN alternates.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Requester, memory-port and status signals of dmem_port_arbiter.
// The m1_lock signal exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic              m1_lock;
`endif

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
`ifdef DMEM_ARB_LOCK_EN
    input  m1_lock,
`endif
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
`ifdef DMEM_ARB_LOCK_EN
    output m1_lock,
`endif
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin owner of the data-memory port shared by m0 (core) and m1 (debug/loader).
// DMEM_ARB_LOCK_EN adds an m1 burst lock; mem_rdata is sampled on the MEM_LAT-th edge after mem_en rises.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic                clk,
  input logic                reset_n,
  dmem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] { IDLE, ACCESS, RESP } state_t;

  localparam logic [1:0]        LAT_INIT  = 2'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state, state_nxt;
  logic [1:0]        lat_cnt, lat_cnt_nxt;
  logic              rr_last, rr_last_nxt;
  logic              cur_we, cur_we_nxt;
  logic              cur_id, cur_id_nxt;
  logic              capture;

  logic              m0_gnt_q, m0_gnt_nxt, m1_gnt_q, m1_gnt_nxt;
  logic              m0_rvalid_q, m0_rvalid_nxt, m1_rvalid_q, m1_rvalid_nxt;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_nxt, m1_rdata_q, m1_rdata_nxt;
  logic              mem_en_q, mem_en_nxt, mem_we_q, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic              busy_q, busy_nxt;

  logic              lock, m0_elig, m1_win, any_req, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_LOCK_EN
  assign lock = bus.m1_lock;
`else
  assign lock = 1'b0;
`endif

  // rr_last: 0 = m0 served last, 1 = m1 served last
  always_comb begin
    m0_elig   = bus.m0_req & ~lock;
    m1_win    = bus.m1_req & (~m0_elig | ~rr_last);
    any_req   = m0_elig | bus.m1_req;
    sel_we    = m1_win ? bus.m1_we    : bus.m0_we;
    sel_addr  = m1_win ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = m1_win ? bus.m1_wdata : bus.m0_wdata;
  end

  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    rr_last_nxt   = rr_last;
    cur_we_nxt    = cur_we;
    cur_id_nxt    = cur_id;
    capture       = 1'b0;
    m0_gnt_nxt    = 1'b0;
    m1_gnt_nxt    = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    busy_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt     = ACCESS;
          cur_id_nxt    = m1_win;
          cur_we_nxt    = sel_we;
          m0_gnt_nxt    = ~m1_win;
          m1_gnt_nxt    = m1_win;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = sel_we;
          mem_addr_nxt  = sel_addr & WORD_MASK;
          mem_wdata_nxt = sel_wdata;
          busy_nxt      = 1'b1;
        end
      end
      ACCESS: begin
        rr_last_nxt = cur_id;
        if (cur_we) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = RESP;
          lat_cnt_nxt = LAT_INIT;
          busy_nxt    = 1'b1;
          capture     = (LAT_INIT == 2'd0);
        end
      end
      RESP: begin
        if (lat_cnt == 2'd0) begin
          state_nxt = IDLE;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
          busy_nxt    = 1'b1;
          capture     = (lat_cnt == 2'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // rdata/rvalid load on entry to the lat_cnt==0 RESP cycle so they are visible during it
    m0_rvalid_nxt = capture & ~cur_id;
    m1_rvalid_nxt = capture & cur_id;
    m0_rdata_nxt  = (capture & ~cur_id) ? bus.mem_rdata : m0_rdata_q;
    m1_rdata_nxt  = (capture & cur_id)  ? bus.mem_rdata : m1_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      rr_last     <= 1'b1;
      cur_we      <= 1'b0;
      cur_id      <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      rr_last     <= rr_last_nxt;
      cur_we      <= cur_we_nxt;
      cur_id      <= cur_id_nxt;
      m0_gnt_q    <= m0_gnt_nxt;
      m1_gnt_q    <= m1_gnt_nxt;
      m0_rvalid_q <= m0_rvalid_nxt;
      m1_rvalid_q <= m1_rvalid_nxt;
      m0_rdata_q  <= m0_rdata_nxt;
      m1_rdata_q  <= m1_rdata_nxt;
      mem_en_q    <= mem_en_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      busy_q      <= busy_nxt;
    end
  end

  assign bus.m0_gnt    = m0_gnt_q;
  assign bus.m1_gnt    = m1_gnt_q;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed opening plus randomized requesters, checked
// every cycle against a transaction-level schedule model.
module tb_dmem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LAT     = 3;
  localparam int NCYC    = 3000;
  localparam int DIR_END = 30;

  typedef struct packed {
    logic        g0, g1, rv0, rv1, en, we, busy;
    logic [31:0] addr, wdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  exp_t        exp_q    [NCYC+8];
  logic [31:0] mem_hist [NCYC+8];
  int unsigned n_cmp, n_bad;
  int          next_idle, busy_cnt, g0_cnt;
  logic        rr_last;
  logic [31:0] m_rd0, m_rd1;

  task automatic chk1(input string name, input int c, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, c, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  task automatic directed(input int c, output logic rst_now);
    rst_now = 1'b0;
    case (c)
      0, 1, 2: reset_n = 1'b0;
      3: begin
        reset_n = 1'b1;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h23; bus.m1_wdata = '0;
      end
      5:  bus.m1_req = 1'b0;
      10: begin bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h40; end
      12: begin bus.m0_req = 1'b0; rst_now = 1'b1; end
      14: begin
        reset_n = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h100; bus.m0_wdata = 32'hA0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h104; bus.m1_wdata = 32'hB1;
      end
      16: bus.m0_req = 1'b0;
      18: bus.m1_req = 1'b0;
      20: begin bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h200; end
      22: begin
        bus.m1_req = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h300;
      end
      23: bus.m0_req = 1'b0;
      default: ;
    endcase
    bus.mem_rdata = 32'hCAFE_0000 + 32'(c);
  endtask

  task automatic random_drive(input int c, output logic rst_now);
    rst_now = 1'b0;
    if (!reset_n) reset_n = 1'b1;
    else if ($urandom_range(0, 299) == 0) rst_now = 1'b1;
    if (bus.m0_req && exp_q[c-1].g0) begin
      if ($urandom_range(0, 3) != 0) begin
        bus.m0_we = 1'($urandom_range(0, 1)); bus.m0_addr = $urandom; bus.m0_wdata = $urandom;
      end else bus.m0_req = 1'b0;
    end else if (bus.m0_req) begin
      if ($urandom_range(0, 15) == 0) bus.m0_req = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      bus.m0_req = 1'b1;
      bus.m0_we = 1'($urandom_range(0, 1)); bus.m0_addr = $urandom; bus.m0_wdata = $urandom;
    end
    if (bus.m1_req && exp_q[c-1].g1) begin
      if ($urandom_range(0, 3) != 0) begin
        bus.m1_we = 1'($urandom_range(0, 1)); bus.m1_addr = $urandom; bus.m1_wdata = $urandom;
      end else bus.m1_req = 1'b0;
    end else if (bus.m1_req) begin
      if ($urandom_range(0, 15) == 0) bus.m1_req = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      bus.m1_req = 1'b1;
      bus.m1_we = 1'($urandom_range(0, 1)); bus.m1_addr = $urandom; bus.m1_wdata = $urandom;
    end
`ifdef DMEM_ARB_LOCK_EN
    if ($urandom_range(0, 19) == 0) bus.m1_lock = ~bus.m1_lock;
`endif
    bus.mem_rdata = $urandom;
  endtask

  initial begin
    logic rst_now, e0, e1, w, wwe;
    logic [31:0] waddr, wdata;
    exp_t e;
    reset_n = 1'b0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    bus.m1_lock = 1'b0;
`endif
    bus.mem_rdata = '0;
    for (int k = 0; k < NCYC + 8; k++) begin exp_q[k] = '0; mem_hist[k] = '0; end
    n_cmp = 0; n_bad = 0; next_idle = 0; busy_cnt = 0; g0_cnt = 0;
    rr_last = 1'b1; m_rd0 = '0; m_rd1 = '0;
    @(posedge clk); #1;
    for (int c = 0; c < NCYC; c++) begin
      if (c < DIR_END) directed(c, rst_now);
      else random_drive(c, rst_now);
      if (rst_now) begin #2; reset_n = 1'b0; end
      @(negedge clk);
      mem_hist[c] = bus.mem_rdata;

      if (!reset_n) begin
        for (int k = c; k < c + 8; k++) exp_q[k] = '0;
        next_idle = c + 1; rr_last = 1'b1; m_rd0 = '0; m_rd1 = '0;
      end
      e = exp_q[c];
      if (e.rv0) m_rd0 = mem_hist[c-1];
      if (e.rv1) m_rd1 = mem_hist[c-1];

      chk1 ("m0_gnt",    c, bus.m0_gnt,    e.g0);
      chk1 ("m1_gnt",    c, bus.m1_gnt,    e.g1);
      chk1 ("m0_rvalid", c, bus.m0_rvalid, e.rv0);
      chk1 ("m1_rvalid", c, bus.m1_rvalid, e.rv1);
      chk32("m0_rdata",  c, bus.m0_rdata,  m_rd0);
      chk32("m1_rdata",  c, bus.m1_rdata,  m_rd1);
      chk1 ("mem_en",    c, bus.mem_en,    e.en);
      chk1 ("mem_we",    c, bus.mem_we,    e.we);
      chk32("mem_addr",  c, bus.mem_addr,  e.addr);
      chk32("mem_wdata", c, bus.mem_wdata, e.wdata);
      chk1 ("busy",      c, bus.busy,      e.busy);

      if (c >= 3 && c <= 9 && bus.busy) busy_cnt++;
      if (c >= 20 && c <= 29 && bus.m0_gnt) g0_cnt++;
      if (c == 4) begin
        chk1 ("lit_m1_gnt",   c, bus.m1_gnt, 1'b1);
        chk32("lit_mem_addr", c, bus.mem_addr, 32'h20);
      end
      if (c == 7) begin
        chk1 ("lit_m1_rvalid", c, bus.m1_rvalid, 1'b1);
        chk32("lit_m1_rdata",  c, bus.m1_rdata, 32'hCAFE_0006);
      end
      if (c == 9)  chk32("lit_busy_len", c, busy_cnt, 32'd4);
      if (c == 12) chk1 ("lit_rst_busy", c, bus.busy, 1'b0);
      if (c == 14) chk1 ("lit_no_rvalid_after_rst", c, bus.m0_rvalid, 1'b0);
      if (c == 15) begin
        chk1 ("lit_tie_m0_gnt", c, bus.m0_gnt, 1'b1);
        chk32("lit_tie_wdata",  c, bus.mem_wdata, 32'hA0);
      end
      if (c == 17) begin
        chk1 ("lit_m1_next_gnt", c, bus.m1_gnt, 1'b1);
        chk32("lit_m1_wdata",    c, bus.mem_wdata, 32'hB1);
      end
      if (c == 29) chk32("lit_withdrawn", c, g0_cnt, 32'd0);

      // Schedule model: a grant decided in cycle c shows at c+1; reads return at c+1+LAT
      if (reset_n && c >= next_idle) begin
        e0 = bus.m0_req;
`ifdef DMEM_ARB_LOCK_EN
        if (bus.m1_lock) e0 = 1'b0;
`endif
        e1 = bus.m1_req;
        if (e0 || e1) begin
          w     = (e0 && e1) ? ~rr_last : e1;
          wwe   = w ? bus.m1_we    : bus.m0_we;
          waddr = w ? bus.m1_addr  : bus.m0_addr;
          wdata = w ? bus.m1_wdata : bus.m0_wdata;
          exp_q[c+1].g0    = ~w;
          exp_q[c+1].g1    = w;
          exp_q[c+1].en    = 1'b1;
          exp_q[c+1].we    = wwe;
          exp_q[c+1].addr  = {waddr[31:2], 2'b00};
          exp_q[c+1].wdata = wdata;
          exp_q[c+1].busy  = 1'b1;
          if (wwe) next_idle = c + 2;
          else begin
            for (int k = 2; k <= LAT + 1; k++) exp_q[c+k].busy = 1'b1;
            if (w) exp_q[c+1+LAT].rv1 = 1'b1;
            else   exp_q[c+1+LAT].rv0 = 1'b1;
            next_idle = c + 2 + LAT;
          end
          rr_last = w;
        end
      end
      @(posedge clk); #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
